// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT address sequencer.
// Optional IFFT support is enabled with the FFT_INVERSE_EN macro.
package fft_pkg;

    localparam int FFT_N_POINTS = 1024;
    localparam int FFT_LOG2N    = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } fft_ctrl_state_t;

    typedef logic [FFT_LOG2N-1:0] fft_addr_t;
    typedef logic [FFT_LOG2N-2:0] fft_tw_addr_t;

    function automatic int fft_pipe(
        input int rd_lat,
        input int bf_lat
    );
        return rd_lat + bf_lat;
    endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// Stall-holdable shift register carrying the read strobe and address
// pair forward so write-back lines up with the butterfly outputs.
module fft_addr_delay
    import fft_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = FFT_LOG2N
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          in_valid,
    input  logic [AW-1:0] in_a,
    input  logic [AW-1:0] in_b,
    output logic          out_valid,
    output logic [AW-1:0] out_a,
    output logic [AW-1:0] out_b
);

    logic [DEPTH-1:0]         vld_q, vld_d;
    logic [DEPTH-1:0][AW-1:0] a_q, a_d;
    logic [DEPTH-1:0][AW-1:0] b_q, b_d;

    always_comb begin
        vld_d = vld_q;
        a_d   = a_q;
        b_d   = b_q;
        if (en) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                vld_d[i] = vld_q[i-1];
                a_d[i]   = a_q[i-1];
                b_d[i]   = b_q[i-1];
            end
            vld_d[0] = in_valid;
            a_d[0]   = in_a;
            b_d[0]   = in_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            vld_q <= vld_d;
            a_q   <= a_d;
            b_q   <= b_d;
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_a     = a_q[DEPTH-1];
    assign out_b     = b_q[DEPTH-1];

endmodule

// File: rtl/fft_ctrl.sv
// In-place radix-2 DIT FFT sequencer: read pairs, twiddle index, delayed
// write-back. Define FFT_INVERSE_EN to add the inverse/tw_conj ports.
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int N_POINTS     = FFT_N_POINTS,
    parameter int LOG2N        = FFT_LOG2N,
    parameter int RD_LATENCY   = 1,
    parameter int BFLY_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
`ifdef FFT_INVERSE_EN
    input  logic                     inverse,
    output logic                     tw_conj,
`endif
    input  logic                     stall,
    output logic                     rd_en,
    output logic [LOG2N-1:0]         rd_addr_a,
    output logic [LOG2N-1:0]         rd_addr_b,
    output logic [LOG2N-2:0]         tw_addr,
    output logic                     wr_en,
    output logic [LOG2N-1:0]         wr_addr_a,
    output logic [LOG2N-1:0]         wr_addr_b,
    output logic [$clog2(LOG2N)-1:0] stage,
    output logic                     busy,
    output logic                     done
);

    localparam int PIPE = fft_pipe(RD_LATENCY, BFLY_LATENCY);
    localparam int HALF = N_POINTS / 2;
    localparam int KW   = LOG2N - 1;
    localparam int SW   = $clog2(LOG2N);
    localparam int DW   = (PIPE > 1) ? $clog2(PIPE) : 1;

    function automatic logic [LOG2N-1:0] span_of(input int s);
        return LOG2N'(1) << s;
    endfunction

    function automatic logic [LOG2N-1:0] pair_a(
        input logic [LOG2N-1:0] kx,
        input int               s
    );
        logic [LOG2N-1:0] msk;
        msk = span_of(s) - LOG2N'(1);
        return ((kx >> s) << (s + 1)) | (kx & msk);
    endfunction

    function automatic logic [KW-1:0] tw_of(
        input logic [LOG2N-1:0] kx,
        input int               s
    );
        logic [LOG2N-1:0] t;
        t = (kx & (span_of(s) - LOG2N'(1))) << (LOG2N - 1 - s);
        return t[KW-1:0];
    endfunction

    fft_ctrl_state_t  state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic             rd_en_q, rd_en_d;
    logic [LOG2N-1:0] rd_a_q, rd_a_d;
    logic [LOG2N-1:0] rd_b_q, rd_b_d;
    logic [KW-1:0]    tw_q, tw_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             inv_q, inv_d;

    logic             ld;
    logic [KW-1:0]    ld_k;
    logic [SW-1:0]    ld_s;
    logic [LOG2N-1:0] ld_a;
    logic             wr_v;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stage_d = stage_q;
        drain_d = drain_q;
        rd_en_d = rd_en_q;
        rd_a_d  = rd_a_q;
        rd_b_d  = rd_b_q;
        tw_d    = tw_q;
        busy_d  = busy_q;
        done_d  = done_q;
        inv_d   = inv_q;
        ld      = 1'b0;
        ld_k    = '0;
        ld_s    = '0;
        ld_a    = '0;
        // A stalled cycle freezes every register, including start capture.
        if (!stall) begin
            rd_en_d = 1'b0;
            done_d  = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_ISSUE;
                        k_d     = '0;
                        stage_d = '0;
                        busy_d  = 1'b1;
                        ld      = 1'b1;
`ifdef FFT_INVERSE_EN
                        inv_d   = inverse;
`else
                        inv_d   = 1'b0;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (int'(k_q) == HALF - 1) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end else begin
                        k_d  = k_q + KW'(1);
                        ld   = 1'b1;
                        ld_k = k_d;
                        ld_s = stage_q;
                    end
                end
                ST_DRAIN: begin
                    if (int'(drain_q) == PIPE - 1) begin
                        if (int'(stage_q) == LOG2N - 1) begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_ISSUE;
                            stage_d = stage_q + SW'(1);
                            k_d     = '0;
                            ld      = 1'b1;
                            ld_s    = stage_d;
                        end
                    end else begin
                        drain_d = drain_q + DW'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            if (ld) begin
                ld_a    = pair_a(LOG2N'(ld_k), int'(ld_s));
                rd_en_d = 1'b1;
                rd_a_d  = ld_a;
                rd_b_d  = ld_a + span_of(int'(ld_s));
                tw_d    = tw_of(LOG2N'(ld_k), int'(ld_s));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            stage_q <= '0;
            drain_q <= '0;
            rd_en_q <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            tw_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            stage_q <= stage_d;
            drain_q <= drain_d;
            rd_en_q <= rd_en_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
            tw_q    <= tw_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            inv_q   <= inv_d;
        end
    end

    fft_addr_delay #(
        .DEPTH (PIPE),
        .AW    (LOG2N)
    ) u_dly (
        .clk       (clk),
        .rst       (rst),
        .en        (!stall),
        .in_valid  (rd_en_q),
        .in_a      (rd_a_q),
        .in_b      (rd_b_q),
        .out_valid (wr_v),
        .out_a     (wr_addr_a),
        .out_b     (wr_addr_b)
    );

    assign rd_en     = rd_en_q & ~stall;
    assign wr_en     = wr_v & ~stall;
    assign rd_addr_a = rd_a_q;
    assign rd_addr_b = rd_b_q;
    assign tw_addr   = tw_q;
    assign stage     = stage_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef FFT_INVERSE_EN
    assign tw_conj = busy_q & inv_q;
`else
    logic unused_inv;
    assign unused_inv = inv_q;
`endif

endmodule

// File: tb/tb_fft_ctrl.sv
// Bench for fft_ctrl (N=8): directed literal runs plus randomized
// start/stall/reset traffic against a position-based reference model.
module tb_fft_ctrl;

    localparam int N    = 8;
    localparam int LG   = 3;
    localparam int RDL  = 1;
    localparam int BFL  = 1;
    localparam int PIPE = RDL + BFL;
    localparam int H    = N / 2;
    localparam int SEG  = H + PIPE;
    localparam int L    = LG * SEG;

    logic          clk = 1'b0;
    logic          rst, start, stall, inverse;
    logic          rd_en, wr_en, busy, done, tw_conj;
    logic [LG-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [LG-2:0] tw_addr;
    logic [1:0]    stage;

    always #5 clk = ~clk;

    fft_ctrl #(
        .N_POINTS     (N),
        .LOG2N        (LG),
        .RD_LATENCY   (RDL),
        .BFLY_LATENCY (BFL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef FFT_INVERSE_EN
        .inverse   (inverse),
        .tw_conj   (tw_conj),
`endif
        .stall     (stall),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .stage     (stage),
        .busy      (busy),
        .done      (done)
    );

`ifndef FFT_INVERSE_EN
    assign tw_conj = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    bit chk_en  = 0;

    task automatic chk(
        input string       nm,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: transform position counts unstalled edges.
    typedef struct {
        int v;
        int a;
        int b;
    } wr_t;

    int  pos;
    int  m_rd_v, m_a, m_b, m_tw, m_stage, m_inv;
    wr_t hist[$];

    function automatic void model_reset();
        wr_t z;
        z = '{0, 0, 0};
        pos = 0;
        m_rd_v = 0; m_a = 0; m_b = 0;
        m_tw = 0; m_stage = 0; m_inv = 0;
        hist.delete();
        for (int i = 0; i < PIPE; i++) hist.push_back(z);
    endfunction

    function automatic void model_edge();
        wr_t e;
        int  s, loc, span;
        e = '{m_rd_v, m_a, m_b};
        hist.push_front(e);
        void'(hist.pop_back());
        if (pos == 0) begin
            if (start) begin
                pos = 1;
                m_inv = int'(inverse);
            end
        end else if (pos == L + 1) begin
            pos = 0;
        end else begin
            pos++;
        end
        m_rd_v = 0;
        if (pos >= 1 && pos <= L) begin
            s = (pos - 1) / SEG;
            loc = (pos - 1) % SEG;
            m_stage = s;
            if (loc < H) begin
                span = 1 << s;
                m_rd_v = 1;
                m_a = (loc / span) * 2 * span + loc % span;
                m_b = m_a + span;
                m_tw = (loc % span) * (H / span);
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else if (!stall) model_edge();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_rd_en", rd_en, m_rd_v != 0 && !stall);
            chk("cmp_rd_a", rd_addr_a, m_a);
            chk("cmp_rd_b", rd_addr_b, m_b);
            chk("cmp_tw", tw_addr, m_tw);
            chk("cmp_wr_en", wr_en,
                hist[PIPE-1].v != 0 && !stall);
            chk("cmp_wr_a", wr_addr_a, hist[PIPE-1].a);
            chk("cmp_wr_b", wr_addr_b, hist[PIPE-1].b);
            chk("cmp_busy", busy, pos >= 1 && pos <= L);
            chk("cmp_done", done, pos == L + 1);
            chk("cmp_stage", stage, m_stage);
`ifdef FFT_INVERSE_EN
            chk("cmp_tw_conj", tw_conj,
                (pos >= 1 && pos <= L) ? m_inv : 0);
`endif
            if (done && !rst) n_done++;
        end
    end

    // Hand-derived issue schedule for N=8, PIPE=2.
    int lc[12] = '{1, 2, 3, 4, 7, 8, 9, 10, 13, 14, 15, 16};
    int la[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int lb[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int lt[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    function automatic int find(input int c);
        for (int i = 0; i < 12; i++)
            if (lc[i] == c) return i;
        return -1;
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx, w;
        model_reset();
        rst = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        inverse = 1'b0;
        @(negedge clk);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stage", stage, 0);
        chk("rst_rd_a", rd_addr_a, 0);
        chk_en = 1;
        next();
        rst = 1'b0;
        next();

        // Nominal forward/inverse run, literal schedule.
        start = 1'b1;
        inverse = 1'b1;
        for (int c = 0; c <= 21; c++) begin
            if (c > 0) begin
                next();
                start = 1'b0;
            end
            @(negedge clk);
            if (c >= 1) begin
                idx = find(c);
                chk($sformatf("nom_rd_en_c%0d", c), rd_en, idx >= 0);
                if (idx >= 0) begin
                    chk("nom_rd_a", rd_addr_a, la[idx]);
                    chk("nom_rd_b", rd_addr_b, lb[idx]);
                    chk("nom_tw", tw_addr, lt[idx]);
                end
                w = find(c - PIPE);
                chk($sformatf("nom_wr_en_c%0d", c), wr_en, w >= 0);
                if (w >= 0) begin
                    chk("nom_wr_a", wr_addr_a, la[w]);
                    chk("nom_wr_b", wr_addr_b, lb[w]);
                end
                chk($sformatf("nom_done_c%0d", c), done, c == 19);
                chk("nom_busy", busy, c >= 1 && c <= 18);
                if (c <= 18) chk("nom_stage", stage, (c - 1) / 6);
`ifdef FFT_INVERSE_EN
                chk("nom_tw_conj", tw_conj, c >= 1 && c <= 18);
`endif
            end
        end

        // Three-cycle stall starting in cycle 2.
        next();
        start = 1'b1;
        inverse = 1'b0;
        for (int c = 0; c <= 24; c++) begin
            if (c > 0) begin
                next();
                start = 1'b0;
                stall = (c >= 2 && c <= 4);
            end
            @(negedge clk);
            if (c >= 2 && c <= 4) begin
                chk("stl_rd_en_low", rd_en, 0);
                chk("stl_wr_en_low", wr_en, 0);
            end
            if (c >= 2 && c <= 5) begin
                chk("stl_rd_a_hold", rd_addr_a, 2);
                chk("stl_rd_b_hold", rd_addr_b, 3);
            end
            if (c == 5) chk("stl_resume", rd_en, 1);
            if (c >= 1) chk($sformatf("stl_done_c%0d", c), done, c == 22);
        end
        stall = 1'b0;

        // Reset in the middle of stage 1.
        next();
        start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            next();
            start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_rd_en", rd_en, 0);
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_stage", stage, 0);
        chk("mid_rst_addr", {rd_addr_a, rd_addr_b, tw_addr}, 0);
        chk("mid_rst_wraddr", {wr_addr_a, wr_addr_b}, 0);
        next();
        rst = 1'b0;
        next();
        start = 1'b1;
        next();
        start = 1'b0;
        @(negedge clk);
        chk("restart_rd_en", rd_en, 1);
        chk("restart_rd_a", rd_addr_a, 0);
        chk("restart_rd_b", rd_addr_b, 1);

        // Random traffic, checked every cycle by the compare process.
        n_done = 0;
        for (int i = 0; i < 3000; i++) begin
            next();
            start = ($urandom % 6) == 0;
            stall = ($urandom % 4) == 0;
            inverse = $urandom % 2;
            rst = ($urandom % 700) == 0;
        end
        next();
        rst = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        repeat (3) next();
        chk("rand_done_seen", n_done > 20, 1);
        chk_en = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_ctrl.md
# fft_ctrl

Sequencer driving the shared `butterfly_unit` through an in-place radix-2 DIT FFT over an N-point sample memory. On `start` it walks every stage and butterfly, issuing:
- read-address pairs to the sample memory,
- a twiddle-ROM index,
- delayed write-back addresses aligned to the butterfly outputs.

It sits between the accelerator command logic (`start`/`done`) and the sample RAM, twiddle ROM and butterfly datapath.

## Interface
- `N_POINTS`, 1024: transform size; power of two, ≥ 4.
- `LOG2N`, 10: log2(N_POINTS).
- `RD_LATENCY`, 1: sample-RAM read latency in cycles, ≥ 1.
- `BFLY_LATENCY`, 1: `butterfly_unit` register latency in cycles, ≥ 0.
- Derived `PIPE` = RD_LATENCY + BFLY_LATENCY.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a transform.
- `stall`  in  1  memory back-pressure; freezes the sequencer and delay line.
- `rd_en`  out  1  read strobe for the A/B pair.
- `rd_addr_a`, `rd_addr_b`  out  LOG2N  read addresses.
- `tw_addr`  out  LOG2N-1  twiddle-ROM index, issued with `rd_en`.
- `wr_en`  out  1  write strobe for butterfly results.
- `wr_addr_a`, `wr_addr_b`  out  LOG2N  write-back addresses.
- `stage`  out  $clog2(LOG2N)  current stage index.
- `busy`  out  1  high from the first issue cycle through the last drain cycle.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: `start` → ISSUE with `stage` = 0 and `k` = 0. `start` is ignored in every other state.
- ISSUE: one butterfly per unstalled cycle, `k` = 0..N/2-1. With `s` = stage, `span` = 1<<s and `pos` = k & (span-1):
  - `rd_addr_a` = ((k>>s)<<(s+1)) | pos
  - `rd_addr_b` = `rd_addr_a` + span
  - `tw_addr` = pos << (LOG2N-1-s)
- After `k` = N/2-1 → DRAIN.
- DRAIN: lasts exactly PIPE unstalled cycles so the stage's last write lands before the next stage's first read (read-after-write hazard).
  - If `stage` < LOG2N-1: increment `stage`, clear `k`, go to ISSUE.
  - Otherwise → DONE.
- DONE: `done` = 1 for one cycle, then → IDLE.
- Write path: {`rd_en`, `rd_addr_a`, `rd_addr_b`} enters a PIPE-deep delay line. Its output drives `wr_en`, `wr_addr_a` and `wr_addr_b`.
- `stall` = 1 holds all of the following; state, counters, delay line and outputs keep their values:
  - `rd_en` and `wr_en` are forced to 0.
  - IDLE ignores `start` while stalled.
- All address arithmetic is unsigned and modulo 2^LOG2N. No wrap can occur for legal parameters.

## Timing
- Reset values: `rd_en`, `wr_en`, `busy`, `done`, `stage`, every address output = 0. Delay line cleared. FSM in IDLE.
- `start` is sampled at edge 0; the first `rd_en` is in cycle 1.
- `wr_en` for an issue in cycle t appears in cycle t+PIPE, absent stalls.
- Unstalled transform: LOG2N·(N/2 + PIPE) busy cycles, then `done` in the following cycle.
- `rst` mid-transform immediately returns to the reset state. In-flight writes are discarded and `done` is not pulsed.
- `start` coinciding with `done` is ignored.

## Configuration
- `FFT_INVERSE_EN` defined:
  - Adds input `inverse` (1 bit), latched on accepted `start`.
  - Adds output `tw_conj` (1 bit), equal to the latched value while `busy`, else 0; the datapath conjugates twiddles for the IFFT.
- `FFT_INVERSE_EN` undefined: neither port exists and the behaviour is forward FFT only.

## Structure
- Package `fft_pkg` holds:
  - `N_POINTS` and `LOG2N` defaults;
  - the state enum `fft_ctrl_state_t`;
  - address typedef `fft_addr_t` (logic [LOG2N-1:0]) and `fft_tw_addr_t`.
- Sub-module `fft_addr_delay`: a parameterised-depth shift register with a stall-hold enable and async clear. It carries the valid bit and the two addresses.

## Test plan
Bench uses N_POINTS=8, LOG2N=3, RD_LATENCY=1, BFLY_LATENCY=1 unless noted.
- Stage 0 issue: `start` at cycle 0 → cycles 1–4 give pairs (0,1), (2,3), (4,5), (6,7), all with `tw_addr` 0.
- Stages 1–2 issue:
  - Stage 1, cycles 7–10: (0,2)/0, (1,3)/2, (4,6)/0, (5,7)/2.
  - Stage 2, cycles 13–16: (0,4)/0, (1,5)/1, (2,6)/2, (3,7)/3.
  - `done` at cycle 19 only.
- Write alignment: each `wr_en` appears exactly 2 cycles after its `rd_en` with identical addresses. No stage-n+1 read occurs before the final stage-n write.
- Stall: hold `stall` high for 3 cycles in cycle 2 → `rd_en`/`wr_en` are low and outputs are held, the sequence resumes at pair (2,3), and `done` moves to cycle 22.
- Reset mid-run: assert `rst` in cycle 9 → all outputs are 0 asynchronously. A subsequent `start` restarts at stage 0 pair (0,1).
- `FFT_INVERSE_EN` build: `start` with `inverse`=1 → `tw_conj`=1 in cycles 1–18 and 0 afterwards. Addresses are identical to the forward run.
